// File: rtl/usb_tx_arbiter_if.sv
// usb_tx_arbiter_if: requester, status and TX FIFO signals of the USB TX arbiter.
// Handshake rules for every valid/ready pair on this interface:
//   a payload byte moves on a rising clk edge where ch_valid[i] and ch_ready[i]
//   are both high; ch_valid/ch_data hold until that edge. req_valid/req_length
//   hold until the one-cycle req_ack. tx_write is a strobe that is never high
//   while tx_full is high.
interface usb_tx_arbiter_if #(
    parameter int NUM_CH = 2
);
    logic                   usb_powered;
    logic                   arb_flush;
    logic [NUM_CH-1:0]      req_valid;
    logic [16*NUM_CH-1:0]   req_length;
    logic [NUM_CH-1:0]      req_ack;
    logic [NUM_CH-1:0]      ch_valid;
    logic [8*NUM_CH-1:0]    ch_data;
    logic [NUM_CH-1:0]      ch_ready;
    logic [NUM_CH-1:0]      pkt_done;
    logic [NUM_CH-1:0]      pkt_abort;
    logic                   busy;
    logic [1:0]             grant_id;
    logic                   tx_full;
    logic                   tx_write;
    logic [7:0]             tx_wdata;
    logic [1:0]             dbg_state;

    // Requesters, FIFO status and control side.
    modport master (
        output usb_powered, arb_flush, req_valid, req_length, ch_valid, ch_data, tx_full,
        input  req_ack, ch_ready, pkt_done, pkt_abort, busy, grant_id, tx_write, tx_wdata,
               dbg_state
    );

    // Arbiter side.
    modport slave (
        input  usb_powered, arb_flush, req_valid, req_length, ch_valid, ch_data, tx_full,
        output req_ack, ch_ready, pkt_done, pkt_abort, busy, grant_id, tx_write, tx_wdata,
               dbg_state
    );
endinterface

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: round-robin packet framer in front of the USB TX byte FIFO.
// Each granted packet is written as A5, channel id, length hi, length lo, payload.
// While USB is unpowered the payload is consumed and dropped so requesters
// always complete. dbg_state exposes the FSM state for checkers.
module usb_tx_arbiter #(
    parameter int NUM_CH = 2
) (
    input logic             clk,
    input logic             rst,
    usb_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        grant_id;
    logic [1:0]        rr_ptr;
    logic [1:0]        hdr_idx;
    logic [15:0]       remaining;
    logic [NUM_CH-1:0] req_ack_q;
    logic [NUM_CH-1:0] pkt_done_q;
    logic [NUM_CH-1:0] pkt_abort_q;
    logic              powered_meta;
    logic              powered_sync;

    logic              drain;
    logic              accept;
    logic              found;
    logic [1:0]        sel_id;
    logic [15:0]       sel_len;
    logic [NUM_CH-1:0] sel_onehot;
    logic [NUM_CH-1:0] gnt_onehot;
    logic [7:0]        sel_data;
    logic              sel_valid;
    logic [7:0]        hdr_byte;
    logic              hdr_step;
    logic              pay_step;
    logic [1:0]        next_ptr;

    // Two-flop synchronizer for the asynchronous power-detect input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            powered_meta <= 1'b0;
            powered_sync <= 1'b0;
        end else begin
            powered_meta <= bus.usb_powered;
            powered_sync <= powered_meta;
        end
    end

    assign drain  = !powered_sync;
    // A byte may leave this cycle: the FIFO has room or we are discarding,
    // and no abort is being taken.
    assign accept = (drain || !bus.tx_full) && !bus.arb_flush;

    // Round-robin search: the requester closest at or above rr_ptr (with wrap) wins.
    always_comb begin
        found      = 1'b0;
        sel_id     = 2'd0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && bus.req_valid[i] &&
                    (((i - int'(rr_ptr) + NUM_CH) % NUM_CH) == k)) begin
                    found  = 1'b1;
                    sel_id = 2'(i);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            sel_onehot[i] = found && (sel_id == 2'(i));
        end
    end

    // Per-channel muxes: length of the winning requester, payload of the granted one.
    always_comb begin
        sel_len    = 16'd0;
        sel_data   = 8'd0;
        sel_valid  = 1'b0;
        gnt_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_id == 2'(i)) begin
                sel_len = bus.req_length[i*16 +: 16];
            end
            if (grant_id == 2'(i)) begin
                sel_data      = bus.ch_data[i*8 +: 8];
                sel_valid     = bus.ch_valid[i];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    // Header byte for the current index; remaining still holds the full length here.
    always_comb begin
        case (hdr_idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = {6'b0, grant_id};
            2'd2:    hdr_byte = remaining[15:8];
            default: hdr_byte = remaining[7:0];
        endcase
    end

    assign hdr_step = (state == HEADER) && accept;
    assign pay_step = (state == PAYLOAD) && accept && sel_valid;
    assign next_ptr = (grant_id == 2'(NUM_CH - 1)) ? 2'd0 : grant_id + 2'd1;

    assign bus.ch_ready  = ((state == PAYLOAD) && accept) ? gnt_onehot : '0;
    assign bus.tx_write  = !drain && (hdr_step || pay_step);
    assign bus.tx_wdata  = (state == PAYLOAD) ? sel_data : hdr_byte;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant_id;
    assign bus.req_ack   = req_ack_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_abort = pkt_abort_q;
    assign bus.dbg_state = state;

    // Packet FSM: grant, header, payload, completion; pulses are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_id    <= 2'd0;
            rr_ptr      <= 2'd0;
            hdr_idx     <= 2'd0;
            remaining   <= 16'd0;
            req_ack_q   <= '0;
            pkt_done_q  <= '0;
            pkt_abort_q <= '0;
        end else begin
            req_ack_q   <= '0;
            pkt_done_q  <= '0;
            pkt_abort_q <= '0;
            case (state)
                IDLE: begin
                    // a flush seen in IDLE only suppresses arbitration this cycle
                    if (!bus.arb_flush && found) begin
                        grant_id  <= sel_id;
                        remaining <= sel_len;
                        hdr_idx   <= 2'd0;
                        req_ack_q <= sel_onehot;
                        state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (bus.arb_flush) begin
                        pkt_abort_q <= gnt_onehot;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                    end else if (hdr_step) begin
                        if (hdr_idx == 2'd3) begin
                            if (remaining == 16'd0) begin
                                pkt_done_q <= gnt_onehot;
                                state      <= DONE;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.arb_flush) begin
                        pkt_abort_q <= gnt_onehot;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                    end else if (pay_step) begin
                        // count never wraps below zero; the last byte ends the packet
                        if (remaining <= 16'd1) begin
                            remaining  <= 16'd0;
                            pkt_done_q <= gnt_onehot;
                            state      <= DONE;
                        end else begin
                            remaining <= remaining - 16'd1;
                        end
                    end
                end
                default: begin
                    // DONE: packet already complete, so a flush here changes nothing
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed vector table plus hand-written sequences for
// round robin, abort and asynchronous reset of usb_tx_arbiter.
module tb_usb_tx_arbiter;
    localparam int NUM_CH   = 2;
    localparam int CLK_HALF = 5;

    typedef struct {
        int ch;
        int len;
        bit powered;
        bit toggle_full;
        int exp_done_lat;
        int exp_writes;
        int exp_hs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    usb_tx_arbiter_if #(.NUM_CH(NUM_CH)) bus ();
    usb_tx_arbiter #(.NUM_CH(NUM_CH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // clock and cycle counter
    always #CLK_HALF clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard and event bookkeeping
    logic [7:0]        exp_q[$];
    logic [1:0]        exp_gnt_q[$];
    int                ack_hist[$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                n_writes;
    int                hs_cnt[NUM_CH];
    int                done_cnt[NUM_CH];
    int                abort_cnt[NUM_CH];
    int                done_cyc[NUM_CH];
    int                abort_cyc[NUM_CH];
    logic [NUM_CH-1:0] ack_now, hs_now, done_now, abort_now;

    // requester model
    int len_r[NUM_CH];
    int idx_r[NUM_CH];
    int rep_r[NUM_CH];
    bit toggle_full;
    bit flush_armed;
    int flush_ch, flush_at, flush_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pbyte(input int c, input int k);
        if (c == 0) return 8'((k + 1) * 17);
        return 8'(128 + k * 3);
    endfunction

    task automatic exp_packet(input int c, input int len, input bit written);
        exp_gnt_q.push_back(2'(c));
        if (written) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(c));
            exp_q.push_back(8'(len >> 8));
            exp_q.push_back(8'(len));
            for (int k = 0; k < len; k++) exp_q.push_back(pbyte(c, k));
        end
    endtask

    // monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            ack_now   = '0;
            hs_now    = '0;
            done_now  = '0;
            abort_now = '0;
        end else begin
            ack_now   = bus.req_ack;
            hs_now    = bus.ch_valid & bus.ch_ready;
            done_now  = bus.pkt_done;
            abort_now = bus.pkt_abort;
            if (bus.tx_write) begin
                n_writes++;
                check("write_while_full", 32'(bus.tx_full), 32'd0);
                if (exp_q.size() == 0) check("tx_byte_unexpected", 32'(bus.tx_wdata), 32'h1FF);
                else check("tx_byte", 32'(bus.tx_wdata), 32'(exp_q.pop_front()));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ack_now[c]) begin
                    ack_hist.push_back(cyc);
                    if (exp_gnt_q.size() == 0) check("grant_unexpected", 32'(bus.grant_id), 32'h1FF);
                    else check("grant_id", 32'(bus.grant_id), 32'(exp_gnt_q.pop_front()));
                end
                if (hs_now[c]) hs_cnt[c]++;
                if (done_now[c]) begin
                    done_cnt[c]++;
                    done_cyc[c] = cyc;
                end
                if (abort_now[c]) begin
                    abort_cnt[c]++;
                    abort_cyc[c] = cyc;
                end
            end
        end
    end

    task automatic start_req(input int c, input int len);
        len_r[c] = len;
        idx_r[c] = 0;
        bus.req_length[c*16 +: 16] = 16'(len);
        bus.req_valid[c] = 1'b1;
        bus.ch_valid[c]  = (len != 0);
        bus.ch_data[c*8 +: 8] = pbyte(c, 0);
    endtask

    // driver: one clock cycle, reacting to what the monitor saw before the edge
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ack_now[c]) bus.req_valid[c] = 1'b0;
            if (hs_now[c]) begin
                idx_r[c]++;
                if (idx_r[c] >= len_r[c]) bus.ch_valid[c] = 1'b0;
                else bus.ch_data[c*8 +: 8] = pbyte(c, idx_r[c]);
            end
            if (abort_now[c]) bus.ch_valid[c] = 1'b0;
            if (done_now[c] && rep_r[c] > 0) begin
                rep_r[c]--;
                start_req(c, len_r[c]);
            end
        end
        bus.tx_full = toggle_full ? !bus.tx_full : 1'b0;
        if (flush_armed && hs_cnt[flush_ch] == flush_at) begin
            bus.arb_flush = 1'b1;
            flush_armed   = 1'b0;
            flush_cyc     = cyc;
        end else begin
            bus.arb_flush = 1'b0;
        end
    endtask

    // reset block: returns with the power synchronizer settled
    task automatic reset_dut(input bit powered);
        rst             = 1'b1;
        bus.usb_powered = powered;
        bus.arb_flush   = 1'b0;
        bus.req_valid   = '0;
        bus.req_length  = '0;
        bus.ch_valid    = '0;
        bus.ch_data     = '0;
        bus.tx_full     = 1'b0;
        toggle_full     = 1'b0;
        flush_armed     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        exp_gnt_q.delete();
        ack_hist.delete();
        n_writes = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            hs_cnt[c]    = 0;
            done_cnt[c]  = 0;
            abort_cnt[c] = 0;
            done_cyc[c]  = -1;
            abort_cyc[c] = -1;
            rep_r[c]     = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   t0;
        int   bound;
        int   ch;

        rst = 1'b1;
        vecs[0] = '{ch:0, len:3,   powered:1, toggle_full:0, exp_done_lat:8,   exp_writes:7,   exp_hs:3};
        vecs[1] = '{ch:1, len:0,   powered:1, toggle_full:0, exp_done_lat:5,   exp_writes:4,   exp_hs:0};
        vecs[2] = '{ch:1, len:256, powered:1, toggle_full:0, exp_done_lat:261, exp_writes:260, exp_hs:256};
        vecs[3] = '{ch:0, len:4,   powered:1, toggle_full:1, exp_done_lat:-1,  exp_writes:8,   exp_hs:4};
        vecs[4] = '{ch:1, len:5,   powered:0, toggle_full:0, exp_done_lat:10,  exp_writes:0,   exp_hs:5};
        vecs[5] = '{ch:0, len:1,   powered:1, toggle_full:0, exp_done_lat:6,   exp_writes:5,   exp_hs:1};

        // reset state
        reset_dut(1'b1);
        check("rst_req_ack",   32'(bus.req_ack),   32'd0);
        check("rst_ch_ready",  32'(bus.ch_ready),  32'd0);
        check("rst_pkt_done",  32'(bus.pkt_done),  32'd0);
        check("rst_pkt_abort", 32'(bus.pkt_abort), 32'd0);
        check("rst_tx_write",  32'(bus.tx_write),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_grant_id",  32'(bus.grant_id),  32'd0);
        check("rst_state",     32'(bus.dbg_state), 32'd0);

        // table-driven single packets
        foreach (vecs[v]) begin
            ch = vecs[v].ch;
            reset_dut(vecs[v].powered);
            exp_packet(ch, vecs[v].len, vecs[v].powered);
            toggle_full = vecs[v].toggle_full;
            t0 = cyc;
            start_req(ch, vecs[v].len);
            bound = 0;
            while (done_cnt[ch] == 0 && bound < 600) begin
                tick();
                bound++;
            end
            toggle_full = 1'b0;
            repeat (3) tick();
            check("ack_latency", (ack_hist.size() > 0) ? 32'(ack_hist[0] - t0) : 32'hFFFF_FFFF, 32'd1);
            if (vecs[v].exp_done_lat >= 0)
                check("done_latency", 32'(done_cyc[ch] - t0), 32'(vecs[v].exp_done_lat));
            check("done_count",  32'(done_cnt[ch]),  32'd1);
            check("write_count", 32'(n_writes),      32'(vecs[v].exp_writes));
            check("handshakes",  32'(hs_cnt[ch]),    32'(vecs[v].exp_hs));
            check("abort_count", 32'(abort_cnt[ch]), 32'd0);
            check("sb_leftover", 32'(exp_q.size()),  32'd0);
            check("busy_after",  32'(bus.busy),      32'd0);
        end

        // round robin: both channels request length 1 twice
        reset_dut(1'b1);
        for (int r = 0; r < 2; r++) begin
            exp_packet(0, 1, 1'b1);
            exp_packet(1, 1, 1'b1);
        end
        rep_r[0] = 1;
        rep_r[1] = 1;
        start_req(0, 1);
        start_req(1, 1);
        bound = 0;
        while ((done_cnt[0] + done_cnt[1]) < 4 && bound < 200) begin
            tick();
            bound++;
        end
        repeat (2) tick();
        check("rr_done_ch0",    32'(done_cnt[0]),      32'd2);
        check("rr_done_ch1",    32'(done_cnt[1]),      32'd2);
        check("rr_writes",      32'(n_writes),         32'd20);
        check("rr_grants_left", 32'(exp_gnt_q.size()), 32'd0);
        check("rr_sb_leftover", 32'(exp_q.size()),     32'd0);
        check("rr_ack_gap", (ack_hist.size() > 1) ? 32'(ack_hist[1] - ack_hist[0]) : 32'hFFFF_FFFF, 32'd7);

        // abort during payload byte 2 of a 10-byte packet
        reset_dut(1'b1);
        exp_gnt_q.push_back(2'd0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h0A);
        exp_q.push_back(pbyte(0, 0));
        exp_q.push_back(pbyte(0, 1));
        flush_ch    = 0;
        flush_at    = 2;
        flush_armed = 1'b1;
        start_req(0, 10);
        bound = 0;
        while (abort_cnt[0] == 0 && bound < 100) begin
            tick();
            bound++;
        end
        check("abort_latency", 32'(abort_cyc[0] - flush_cyc), 32'd1);
        check("abort_state",   32'(bus.dbg_state),            32'd0);
        repeat (2) tick();
        check("abort_count",       32'(abort_cnt[0]),  32'd1);
        check("abort_no_done",     32'(done_cnt[0]),   32'd0);
        check("abort_writes",      32'(n_writes),      32'd6);
        check("abort_handshakes",  32'(hs_cnt[0]),     32'd2);
        check("abort_sb_leftover", 32'(exp_q.size()),  32'd0);

        // asynchronous reset in the middle of a header
        reset_dut(1'b1);
        exp_packet(1, 5, 1'b1);
        start_req(1, 5);
        bound = 0;
        while (ack_hist.size() == 0 && bound < 20) begin
            tick();
            bound++;
        end
        check("pre_reset_busy",  32'(bus.busy),     32'd1);
        check("pre_reset_grant", 32'(bus.grant_id), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",      32'(bus.busy),      32'd0);
        check("arst_grant_id",  32'(bus.grant_id),  32'd0);
        check("arst_tx_write",  32'(bus.tx_write),  32'd0);
        check("arst_ch_ready",  32'(bus.ch_ready),  32'd0);
        check("arst_req_ack",   32'(bus.req_ack),   32'd0);
        check("arst_pkt_done",  32'(bus.pkt_done),  32'd0);
        check("arst_state",     32'(bus.dbg_state), 32'd0);
        reset_dut(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
